posit_mul_encode: RTL
=====================

# posit_mul_encode

Pipelined encoder that takes the unpacked product fields of a posit multiply (sign, summed regime, summed exponent, raw mantissa product) and packs them into a WIDTH-bit posit. Handles normalization, regime run construction, round-to-nearest-even, saturation and two's-complement negation. Sits directly downstream of the multiplier field stage and returns results to the standard posit datapath through a valid/ready handshake.

## Interface
- WIDTH, 8, posit word width
- EXP, 2, exponent field width
- REGI, $clog2(WIDTH)+1, per-operand regime width; summed regime input is REGI+1 bits
- MTS, WIDTH-3-EXP, fraction bits per operand; product input is 2*(MTS+1) bits
- Reset rstn, asynchronous, active-low; clock clk_i.
- clk_i  in  1  clock
- rstn  in  1  async active-low reset
- in_vld_i  in  1  input fields valid
- in_rdy_o  out  1  encoder accepts input this cycle
- zero_i  in  1  product is zero (either operand zero)
- nar_i  in  1  product is NaR (either operand NaR; wins over zero_i)
- sign_i  in  1  product sign
- regi_i  in  REGI+1  signed regime sum k_a+k_b
- exp_i  in  EXP+1  unsigned exponent sum e_a+e_b
- mts_i  in  2*(MTS+1)  unsigned product of hidden-bit mantissas, format 01.xxx or 1x.xxx
- out_vld_o  out  1  posit_o valid
- out_rdy_i  in  1  downstream accepts
- posit_o  out  WIDTH  encoded posit

## Operation
- Scale: ovf = mts_i[MSB]; scale = (regi_i <<< EXP) + exp_i + ovf, signed, REGI+EXP+2 bits. k = scale >>> EXP; e = scale[EXP-1:0].
- Fraction: ovf=1 -> f = mts_i[MSB-1:0]; ovf=0 -> f = {mts_i[MSB-2:0],1'b0}. f is 2*MTS+1 bits, MSB-aligned.
- Regime run: k>=0 -> (k+1) ones then one zero; k<0 -> (-k) zeros then one one.
- Body = {regime, e, f}, left-aligned into WIDTH-1 bits; bits shifted out form guard (first dropped) and sticky (OR of rest).
- Round-to-nearest-even: increment when guard & (sticky | lsb).
- Saturation: k >= WIDTH-2 -> magnitude 0111..1 (maxpos); k <= -(WIDTH-1) -> 000..01 (minpos). Rounding never produces 0 (clamp to minpos) and never carries past maxpos.
- Sign: sign_i=1 -> posit_o = two's complement of {1'b0, magnitude}.
- Specials: nar_i -> 1000..0; else zero_i -> 000..0; mts_i/regi_i/exp_i ignored.
- Stages: S1 scale, ovf, fraction align, special flags; S2 regime run build, body shift, guard/sticky; S3 rounding, saturation, negation, output register.

## Timing
- Latency 3 cycles from accepted input (in_vld_i & in_rdy_o) to out_vld_o; throughput 1 per cycle.
- Global stall: en = ~out_vld_o | out_rdy_i; in_rdy_o = en. When en=0 all stage registers, valids and posit_o hold.
- Bubbles propagate as stage valid=0; no bubble collapsing.
- out_vld_o and posit_o stable while out_vld_o & ~out_rdy_i.
- Reset: all stage valids, out_vld_o, posit_o = 0; in_rdy_o = 1 after reset. Reset mid-pipeline discards in-flight data; no output for it.
- Simultaneous accept and output handshake in same cycle: allowed, both complete.

## Test plan
- WIDTH=8,EXP=2: regi=0, exp=0, mts=8'h40, sign=0 -> posit_o 8'h40 three cycles later; same with sign=1 -> 8'hC0.
- regi=0, exp=0, mts=8'h90 (1.5*1.5) -> 8'h49; sign=1 -> 8'hB7.
- RNE ties: mts=8'h44 -> 8'h40 (round down, even); mts=8'h4C -> 8'h42 (round up).
- Saturation/specials: regi=+12 -> 8'h7F; regi=-14 -> 8'h01; nar_i=1 -> 8'h80; zero_i=1 -> 8'h00; nar_i & zero_i -> 8'h80.
- Backpressure: stream 5 inputs, hold out_rdy_i low from cycle 4 for 6 cycles -> in_rdy_o low while out_vld_o high, posit_o held, all 5 results emitted in order, none dropped or duplicated.
- Reset asserted with 2 items in flight -> out_vld_o, posit_o go 0 immediately; after release, no stale outputs, next input emerges after 3 cycles.

Source files
------------

// File: rtl/posit_mul_encode.sv
// Three-stage posit encoder for multiply results: scale/fraction alignment,
// regime construction with guard/sticky extraction, then RNE rounding, saturation and sign.
module posit_mul_encode #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned EXP   = 2,
    parameter int unsigned REGI  = $clog2(WIDTH) + 1,
    parameter int unsigned MTS   = WIDTH - 3 - EXP
) (
    input  logic                  clk_i,
    input  logic                  rstn,
    input  logic                  in_vld_i,
    output logic                  in_rdy_o,
    input  logic                  zero_i,
    input  logic                  nar_i,
    input  logic                  sign_i,
    input  logic [REGI:0]         regi_i,
    input  logic [EXP:0]          exp_i,
    input  logic [2*(MTS+1)-1:0]  mts_i,
    output logic                  out_vld_o,
    input  logic                  out_rdy_i,
    output logic [WIDTH-1:0]      posit_o
);
    localparam int unsigned SW = REGI + EXP + 2;
    localparam int unsigned FW = 2*MTS + 1;
    localparam int unsigned PW = 2*(MTS+1);
    localparam int unsigned VW = 2 + EXP + FW;
    localparam int unsigned NW = VW + WIDTH;
    localparam logic signed [SW-1:0] K_MAX = SW'(WIDTH - 2);
    localparam logic signed [SW-1:0] K_MIN = SW'(-(int'(WIDTH) - 1));

    logic                 w_en;
    logic                 w_ovf;
    logic [SW-1:0]        w_regi_ext;
    logic [SW-1:0]        w_scale;
    logic [FW-1:0]        w_frac;

    logic                 r1_vld, r1_nar, r1_zero, r1_sign;
    logic [SW-1:0]        r1_scale;
    logic [FW-1:0]        r1_frac;

    logic signed [SW-1:0] w_k;
    logic [SW-1:0]        w_sh;
    logic [VW-1:0]        w_seed;
    logic [NW-1:0]        w_ext;
    logic                 w_satmax, w_satmin;

    logic                 r2_vld, r2_nar, r2_zero, r2_sign, r2_satmax, r2_satmin;
    logic [WIDTH-2:0]     r2_body;
    logic                 r2_guard, r2_sticky;

    logic                 w_rnd;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-2:0]     w_mag;
    logic [WIDTH-1:0]     w_res;

    logic                 r_out_vld;
    logic [WIDTH-1:0]     r_posit;

    assign w_en      = ~r_out_vld | out_rdy_i;
    assign in_rdy_o  = w_en;
    assign out_vld_o = r_out_vld;
    assign posit_o   = r_posit;

    // S1: total scale = 2^EXP * k + e, including the carry out of the mantissa product
    assign w_ovf      = mts_i[PW-1];
    assign w_regi_ext = {{(EXP+1){regi_i[REGI]}}, regi_i};
    assign w_scale    = (w_regi_ext << EXP) + SW'(exp_i) + SW'(w_ovf);
    assign w_frac     = w_ovf ? mts_i[PW-2:0] : {mts_i[PW-3:0], 1'b0};

    // S2: seed "10" (k>=0) or "01" (k<0) and sign-extend right; ~k equals -k-1 for k<0
    assign w_k      = $signed(r1_scale) >>> EXP;
    assign w_sh     = w_k[SW-1] ? ~w_k : w_k;
    assign w_seed   = {~w_k[SW-1], w_k[SW-1], r1_scale[EXP-1:0], r1_frac};
    assign w_ext    = $signed({w_seed, {WIDTH{1'b0}}}) >>> w_sh;
    assign w_satmax = (w_k >= K_MAX);
    assign w_satmin = (w_k <= K_MIN);

    // S3: round, clamp into [minpos, maxpos], apply specials and sign
    always_comb begin
        w_rnd = r2_guard & (r2_sticky | r2_body[0]);
        w_sum = {1'b0, r2_body} + WIDTH'(w_rnd);
        if (r2_satmax || w_sum[WIDTH-1]) begin
            w_mag = '1;
        end else if (r2_satmin || (w_sum[WIDTH-2:0] == '0)) begin
            w_mag = {{(WIDTH-2){1'b0}}, 1'b1};
        end else begin
            w_mag = w_sum[WIDTH-2:0];
        end
        if (r2_nar) begin
            w_res = {1'b1, {(WIDTH-1){1'b0}}};
        end else if (r2_zero) begin
            w_res = '0;
        end else if (r2_sign) begin
            w_res = ~{1'b0, w_mag} + WIDTH'(1);
        end else begin
            w_res = {1'b0, w_mag};
        end
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r1_vld    <= 1'b0;
            r1_nar    <= 1'b0;
            r1_zero   <= 1'b0;
            r1_sign   <= 1'b0;
            r1_scale  <= '0;
            r1_frac   <= '0;
            r2_vld    <= 1'b0;
            r2_nar    <= 1'b0;
            r2_zero   <= 1'b0;
            r2_sign   <= 1'b0;
            r2_satmax <= 1'b0;
            r2_satmin <= 1'b0;
            r2_body   <= '0;
            r2_guard  <= 1'b0;
            r2_sticky <= 1'b0;
            r_out_vld <= 1'b0;
            r_posit   <= '0;
        end else if (w_en) begin
            r1_vld    <= in_vld_i;
            r1_nar    <= nar_i;
            r1_zero   <= zero_i & ~nar_i;
            r1_sign   <= sign_i;
            r1_scale  <= w_scale;
            r1_frac   <= w_frac;
            r2_vld    <= r1_vld;
            r2_nar    <= r1_nar;
            r2_zero   <= r1_zero;
            r2_sign   <= r1_sign;
            r2_satmax <= w_satmax;
            r2_satmin <= w_satmin;
            r2_body   <= w_ext[NW-1 -: WIDTH-1];
            r2_guard  <= w_ext[NW-WIDTH];
            r2_sticky <= |w_ext[NW-WIDTH-1:0];
            r_out_vld <= r2_vld;
            if (r2_vld) begin
                r_posit <= w_res;
            end
        end
    end
endmodule
